// File: rtl/sr_imem_loader_if.sv
// Byte-in / instruction-memory-write bus of the boot loader.
// master = loader side, slave = byte source, memory and status observer.
interface sr_imem_loader_if #(
  parameter int ADDR_W = 6
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              imWe;
  logic [ADDR_W-1:0] imWAddr;
  logic [31:0]       imWData;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    input  rx_data, rx_valid,
    output imWe, imWAddr, imWData, cpu_rst_n, busy, done, error
  );

  modport slave (
    output rx_data, rx_valid,
    input  imWe, imWAddr, imWData, cpu_rst_n, busy, done, error
  );
endinterface

// File: rtl/sr_imem_loader.sv
// Boot loader: parses SYNC, LEN(16b LE), LEN*4 data bytes, XOR checksum
// from a byte stream, writes words into instruction memory and holds the
// CPU in reset until a frame verifies.
module sr_imem_loader #(
  parameter int          ADDR_W    = 6,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          TIMEOUT   = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  sr_imem_loader_if.master  bus
);
  localparam int          TW      = $clog2(TIMEOUT + 1);
  localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_W;

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CHECK, RUN, ERROR} state_t;

  state_t            r_state;
  logic [7:0]        r_len_lo;
  logic [16:0]       r_len;
  logic [16:0]       r_wcnt;   // 17 bits so LEN == 2^16 compare cannot wrap
  logic [1:0]        r_bcnt;
  logic [23:0]       r_shift;
  logic [7:0]        r_chk;
  logic [TW-1:0]     r_idle;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic              r_cpu_rst_n;
  logic              r_busy;
  logic              r_done;
  logic              r_error;

  logic        w_in_frame;
  logic        w_sync;
  logic        w_tmo;
  logic [16:0] w_len;
  logic        w_start;
  logic        w_abort;

  assign w_in_frame = (r_state == LEN0) || (r_state == LEN1) ||
                      (r_state == DATA) || (r_state == CHECK);
  assign w_sync  = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
  assign w_tmo   = (r_idle == TW'(TIMEOUT - 1));
  assign w_len   = {1'b0, bus.rx_data, r_len_lo};
  // SYNC only restarts outside a frame; inside a frame it is plain data
  assign w_start = w_sync && !w_in_frame;
  assign w_abort = (w_in_frame && !bus.rx_valid && w_tmo) ||
                   (r_state == LEN1  && bus.rx_valid && (w_len > MAX_LEN)) ||
                   (r_state == CHECK && bus.rx_valid && (bus.rx_data != r_chk));

  // Frame parser, word assembly, memory write and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_len_lo    <= '0;
      r_len       <= '0;
      r_wcnt      <= '0;
      r_bcnt      <= '0;
      r_shift     <= '0;
      r_chk       <= '0;
      r_idle      <= '0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_cpu_rst_n <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_in_frame) begin
        if (bus.rx_valid)  r_idle <= '0;
        else if (!w_tmo)   r_idle <= r_idle + 1'b1;
      end
      case (r_state)
        LEN0: if (bus.rx_valid) begin
          r_len_lo <= bus.rx_data;
          r_state  <= LEN1;
        end
        LEN1: if (bus.rx_valid) begin
          r_len   <= w_len;
          r_state <= (w_len == 17'd0) ? CHECK : DATA;
        end
        DATA: if (bus.rx_valid) begin
          r_chk   <= r_chk ^ bus.rx_data;
          r_bcnt  <= r_bcnt + 2'd1;
          r_shift <= {bus.rx_data, r_shift[23:8]};
          if (r_bcnt == 2'd3) begin
            r_we    <= 1'b1;
            r_waddr <= r_wcnt[ADDR_W-1:0];
            r_wdata <= {bus.rx_data, r_shift};
            r_wcnt  <= r_wcnt + 17'd1;
            if (r_wcnt + 17'd1 == r_len) r_state <= CHECK;
          end
        end
        CHECK: if (bus.rx_valid) begin
          r_state <= RUN;
          r_busy  <= 1'b0;
        end
        // CPU is released one cycle after the checksum verdict
        RUN: begin
          r_done      <= 1'b1;
          r_cpu_rst_n <= 1'b1;
        end
        default: ;
      endcase
      if (w_abort) begin
        r_state     <= ERROR;
        r_error     <= 1'b1;
        r_busy      <= 1'b0;
        r_cpu_rst_n <= 1'b0;
      end
      // Frame start wins over RUN outputs: core goes back into reset at once
      if (w_start) begin
        r_state     <= LEN0;
        r_cpu_rst_n <= 1'b0;
        r_done      <= 1'b0;
        r_error     <= 1'b0;
        r_busy      <= 1'b1;
        r_wcnt      <= '0;
        r_bcnt      <= '0;
        r_chk       <= '0;
        r_idle      <= '0;
      end
    end
  end

  assign bus.imWe      = r_we;
  assign bus.imWAddr   = r_waddr;
  assign bus.imWData   = r_wdata;
  assign bus.cpu_rst_n = r_cpu_rst_n;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.error     = r_error;
endmodule

// File: tb/tb_sr_imem_loader.sv
// Scoreboard bench for sr_imem_loader (ADDR_W=6, TIMEOUT=10).
module tb_sr_imem_loader;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   last_addr = -1;

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];

  sr_imem_loader_if #(.ADDR_W(6)) bus ();

  sr_imem_loader #(.ADDR_W(6), .SYNC_BYTE(8'hA5), .TIMEOUT(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (bus.imWe === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %h data %h, expected none", bus.imWAddr, bus.imWData);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.imWAddr), 32'(e.a));
        chk("wr_data", bus.imWData, e.d);
        last_addr = int'(bus.imWAddr);
      end
    end
  end

  task automatic push(input logic [5:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendg(input logic [7:0] b);
    send(b);
    idle(1);
  endtask

  task automatic chk_status(input string name, input logic cr, input logic bz,
                            input logic dn, input logic er);
    chk({name, "_cpu_rst_n"}, 32'(bus.cpu_rst_n), 32'(cr));
    chk({name, "_busy"},      32'(bus.busy),      32'(bz));
    chk({name, "_done"},      32'(bus.done),      32'(dn));
    chk({name, "_error"},     32'(bus.error),     32'(er));
  endtask

  // Global bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    #12;
    chk("rst_imWe", 32'(bus.imWe), 32'd0);
    chk("rst_imWAddr", 32'(bus.imWAddr), 32'd0);
    chk("rst_imWData", bus.imWData, 32'd0);
    chk_status("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // Nominal LEN=2, bytes with idle gaps; stray byte in IDLE ignored
    sendg(8'h3C);
    chk_status("idle_ignore", 1'b0, 1'b0, 1'b0, 1'b0);
    push(6'd0, 32'h00100013);
    push(6'd1, 32'h00100093);
    sendg(8'hA5);
    chk("nom_busy", 32'(bus.busy), 32'd1);
    sendg(8'h02); sendg(8'h00);
    sendg(8'h13); sendg(8'h00); sendg(8'h10); sendg(8'h00);
    sendg(8'h93); sendg(8'h00); sendg(8'h10); sendg(8'h00);
    send(8'h80);
    chk("nom_done_lag", 32'(bus.done), 32'd0);
    idle(1);
    chk_status("nom", 1'b1, 1'b0, 1'b1, 1'b0);

    // Bad checksum: words still written, then error
    push(6'd0, 32'h00100013);
    push(6'd1, 32'h00100093);
    sendg(8'hA5);
    chk("badchk_cpu_rst", 32'(bus.cpu_rst_n), 32'd0);
    sendg(8'h02); sendg(8'h00);
    sendg(8'h13); sendg(8'h00); sendg(8'h10); sendg(8'h00);
    sendg(8'h93); sendg(8'h00); sendg(8'h10); sendg(8'h00);
    send(8'h81);
    idle(1);
    chk_status("badchk", 1'b0, 1'b0, 1'b0, 1'b1);
    // Empty frame recovers: LEN=0, CHK=0
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    idle(1);
    chk_status("len0", 1'b1, 1'b0, 1'b1, 1'b0);

    // LEN=65 exceeds 64-word memory: error right after LEN_hi, no writes
    send(8'hA5); send(8'h41); send(8'h00);
    chk_status("ovf", 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);

    // LEN=64, back-to-back bytes: word i = {i^5A,22,11,i}; each word XORs
    // to 33^5A=69 and 64 (even) words cancel, so CHK=00
    send(8'hA5); send(8'h40); send(8'h00);
    for (int i = 0; i < 64; i++) begin
      logic [7:0] b0;
      b0 = 8'(i);
      push(6'(i), {b0 ^ 8'h5A, 8'h22, 8'h11, b0});
      send(b0); send(8'h11); send(8'h22); send(b0 ^ 8'h5A);
    end
    send(8'h00);
    idle(1);
    chk_status("len64", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("len64_last_addr", 32'(last_addr), 32'd63);

    // Reload from RUN, rx_valid every cycle: CPU dropped on SYNC
    push(6'd0, 32'h04030201);
    push(6'd1, 32'h08070605);
    push(6'd2, 32'h0C0B0A09);
    send(8'hA5);
    chk_status("reload_sync", 1'b0, 1'b1, 1'b0, 1'b0);
    send(8'h03); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    send(8'h09); send(8'h0A); send(8'h0B); send(8'h0C);
    send(8'h0C);
    idle(1);
    chk_status("reload", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("reload_last_addr", 32'(last_addr), 32'd2);

    // Timeout: 9 idle cycles still busy, 10th aborts
    push(6'd0, 32'h00000000);  // no word completes in this frame, so the queue stays empty
    void'(exp_q.pop_back());
    send(8'hA5); send(8'h02); send(8'h00); send(8'h13);
    idle(9);
    chk_status("tmo9", 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk_status("tmo10", 1'b0, 1'b0, 1'b0, 1'b1);

    // Async reset with a write in flight: pulse dropped, no clock needed
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h13); send(8'h00); send(8'h10); send(8'h00);
    chk("inflight_we", 32'(bus.imWe), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_imWe", 32'(bus.imWe), 32'd0);
    chk("arst_imWAddr", 32'(bus.imWAddr), 32'd0);
    chk("arst_imWData", bus.imWData, 32'd0);
    chk_status("arst", 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    idle(1);
    // Fresh load after reset starts at address 0; CHK = AA^BB^CC^DD = 00
    push(6'd0, 32'hDDCCBBAA);
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    send(8'h00);
    idle(1);
    chk_status("post_rst", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("post_rst_addr", 32'(last_addr), 32'd0);

    idle(2);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sr_imem_loader.md
Name: sr_imem_loader

Overview:
- Boot loader that writes the CPU instruction memory from a byte stream.
- Sits between a byte receiver (e.g. UART RX) and the instruction memory write port. It is the writer side of the word-addressed instruction memory that the CPU core only reads.
- Holds the CPU core in reset while a program image is loaded. Releases the core only after a frame passes its length and checksum checks.

Parameters:
- ADDR_W, 6, instruction memory word-address width; capacity is 2^ADDR_W words.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 1000, maximum idle cycles between bytes inside a frame; minimum value 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid when high; no backpressure
- imWe  out  1  instruction memory write enable
- imWAddr  out  ADDR_W  instruction memory word address
- imWData  out  32  instruction memory write data
- cpu_rst_n  out  1  active-low reset to the CPU core
- busy  out  1  a frame is in progress
- done  out  1  last frame loaded successfully
- error  out  1  last frame aborted

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; all counters, the checksum and the byte shift register cleared.
  - imWe=0, imWAddr=0, imWData=0, cpu_rst_n=0, busy=0, done=0, error=0.
- Frame format: SYNC_BYTE, LEN_lo, LEN_hi, then LEN*4 data bytes, then CHK.
  - LEN is a 16-bit word count.
  - Data words are little-endian: the first byte goes to bits [7:0].
  - CHK is the XOR of all data bytes only.
- States:
  - IDLE: rx_valid with rx_data==SYNC_BYTE -> LEN0. Any other byte is ignored.
  - LEN0: capture LEN_lo -> LEN1.
  - LEN1: capture LEN_hi, then:
    - LEN > 2^ADDR_W -> ERROR.
    - LEN == 0 -> CHECK.
    - otherwise -> DATA.
  - DATA: shift bytes in and count words. After byte 4 of the final word -> CHECK.
  - CHECK: next byte equals the running XOR -> RUN; otherwise -> ERROR.
  - RUN: cpu_rst_n=1, done=1. rx_valid with SYNC_BYTE -> LEN0 and starts a new frame.
  - ERROR: error=1, cpu_rst_n=0. rx_valid with SYNC_BYTE -> LEN0.
- Entering LEN0 from any state:
  - cpu_rst_n=0 in the same cycle the state register updates.
  - done=0, error=0, busy=1.
  - Word address, byte counter and checksum are cleared.
- busy is 1 in LEN0, LEN1, DATA and CHECK; 0 otherwise.
- Memory write timing:
  - The cycle after the 4th byte of a word is accepted, imWe=1 for exactly one cycle. imWAddr carries the word index (first word = 0); imWData carries the assembled word.
  - imWAddr increments after each write.
  - imWAddr and imWData hold their values while imWe=0.
- Word count arithmetic:
  - LEN == 2^ADDR_W is legal. The last write goes to address 2^ADDR_W-1.
  - The word counter is at least 17 bits, so the end-of-data compare never wraps.
- Timeout:
  - In LEN0, LEN1, DATA or CHECK, an idle counter increments on every cycle without rx_valid and clears on rx_valid.
  - Reaching TIMEOUT -> ERROR.
  - IDLE, RUN and ERROR never time out.
- SYNC_BYTE inside a frame (LEN0 through CHECK) is treated as data, not as a restart.
- Partial image: words already written stay in memory after ERROR. The CPU remains in reset.
- Reset mid-frame: immediate return to IDLE and cpu_rst_n=0. A write in flight is dropped; imWe falls asynchronously.
- Consecutive rx_valid on every cycle must be accepted with no byte lost. The back-to-back write pulse for the next word must still appear.

Test Plan:
- Nominal load, LEN=2: bytes A5 02 00, then 13 00 10 00, then 93 00 10 00 -> writes addr0=0x00100013 and addr1=0x00100093. Final byte CHK=0x80 -> done=1 and cpu_rst_n=1, two cycles after CHK.
- Bad checksum: same frame with CHK=0x81 -> both words written, then error=1, done=0, cpu_rst_n=0. A following frame A5 00 00 00 -> done=1.
- Length overflow with ADDR_W=6: LEN=65 (A5 41 00) -> ERROR after LEN_hi, no imWe pulse. LEN=64 loads all words; the last write is to addr 63.
- Timeout with TIMEOUT=10: A5 02 00 13, then 10 idle cycles -> error=1 on cycle 10 and busy=0.
- Reload and stress: from RUN, send a new frame with rx_valid asserted every cycle -> cpu_rst_n drops on SYNC_BYTE. Each word gets exactly one imWe pulse, addresses restart at 0, and done=1 at the end.
- Async reset asserted while in DATA -> all outputs reach their reset values without waiting for a clock edge. The next SYNC_BYTE starts loading again at address 0.
